// File: rtl/nrzi_frame_receiver.sv
// rtl/nrzi_frame_receiver.sv - NRZI serial receiver: bit decode, sync hunt, frame deserialization
module nrzi_frame_receiver #(
  parameter int         WIDTH       = 8,
  parameter logic [7:0] SYNC        = 8'hD5,
  parameter int         FRAME_WORDS = 4,
  parameter int         RUN_MAX     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             line_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_found,
  output logic             frame_done,
  output logic             err,
  output logic             ovf
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(RUN_MAX + 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t           state;
  logic             prev_line;
  logic [7:0]       sync_sr;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [7:0]       word_cnt;
  logic [RW-1:0]    run_cnt;

  logic             d;
  logic [7:0]       sync_nx;
  logic [WIDTH-1:0] shreg_nx;
  logic [BW-1:0]    bit_nx;
  logic [7:0]       word_nx;
  logic [RW-1:0]    run_nx;
  logic             abort;
  logic             word_done;
  logic             frame_end;
  logic             can_load;

  // Next-state values for the bit currently on the line
  always_comb begin
    d        = line_in ^ prev_line;
    sync_nx  = {d, sync_sr[7:1]};
    shreg_nx = {d, shreg[WIDTH-1:1]};
    bit_nx   = bit_cnt + BW'(1);
    word_nx  = word_cnt + 8'd1;
    if (d)
      run_nx = '0;
    else if (run_cnt == RW'(RUN_MAX))
      run_nx = run_cnt;
    else
      run_nx = run_cnt + RW'(1);
    abort     = (run_nx == RW'(RUN_MAX));
    word_done = (bit_nx == BW'(WIDTH));
    frame_end = (word_nx == 8'(FRAME_WORDS));
    // The output register can take a word if empty or being drained this cycle
    can_load  = !out_valid || out_ready;
  end

  // Framing FSM, deserializer and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      prev_line  <= 1'b0;
      sync_sr    <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      run_cnt    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      sync_found <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      sync_found <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (bit_en) begin
        prev_line <= line_in;
        case (state)
          HUNT: begin
            sync_sr <= sync_nx;
            if (sync_nx == SYNC) begin
              sync_found <= 1'b1;
              state      <= RECV;
              bit_cnt    <= '0;
              word_cnt   <= '0;
              run_cnt    <= '0;
            end
          end
          RECV: begin
            shreg   <= shreg_nx;
            run_cnt <= run_nx;
            if (abort) begin
              // Partial word is simply abandoned; a new sync restarts counting
              err     <= 1'b1;
              state   <= HUNT;
              sync_sr <= '0;
              bit_cnt <= '0;
            end else if (word_done) begin
              bit_cnt  <= '0;
              word_cnt <= word_nx;
              if (can_load) begin
                out_data  <= shreg_nx;
                out_valid <= 1'b1;
              end else begin
                ovf <= 1'b1;
              end
              if (frame_end) begin
                frame_done <= 1'b1;
                state      <= HUNT;
                sync_sr    <= '0;
              end
            end else begin
              bit_cnt <= bit_nx;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrzi_frame_receiver.sv
// tb/tb_nrzi_frame_receiver.sv - directed table-driven bench for nrzi_frame_receiver
module tb_nrzi_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_en;
  logic       line_in;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       sync_found;
  logic       frame_done;
  logic       err;
  logic       ovf;

  nrzi_frame_receiver #(
    .WIDTH(8), .SYNC(8'hD5), .FRAME_WORDS(4), .RUN_MAX(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .line_in(line_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sync_found(sync_found), .frame_done(frame_done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] byte_v;
    logic       rdy;
    int         pulse_at;
    logic [3:0] pulses;
    logic       valid;
    logic [7:0] data;
  } vec_t;

  vec_t       tbl[13];
  int         vecs = 0;
  int         miss = 0;
  logic       enc_line;
  logic [7:0] xfer_q[$];
  logic [7:0] exp_xfer[5];

  // Record every handshake transfer, sampled mid-cycle
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) xfer_q.push_back(out_data);

  function automatic logic [3:0] pulses();
    return {sync_found, frame_done, err, ovf};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(logic dbit);
    bit_en   = 1'b1;
    enc_line = enc_line ^ dbit;
    line_in  = enc_line;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
  endtask

  task automatic apply(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      out_ready = tbl[i].rdy;
      for (int b = 0; b < 8; b++) begin
        send_bit(tbl[i].byte_v[b]);
        check($sformatf("v%0d b%0d pulses", i, b), 32'(pulses()),
              (b == tbl[i].pulse_at) ? 32'(tbl[i].pulses) : 32'd0);
      end
      check($sformatf("v%0d valid", i), 32'(out_valid), 32'(tbl[i].valid));
      check($sformatf("v%0d data", i), 32'(out_data), 32'(tbl[i].data));
    end
  endtask

  initial begin
    // pulses field order: {sync_found, frame_done, err, ovf}
    tbl[0]  = '{8'hD5, 1'b1, 7, 4'b1000, 1'b0, 8'h00};
    tbl[1]  = '{8'hA5, 1'b1, 7, 4'b0000, 1'b1, 8'hA5};
    tbl[2]  = '{8'h3C, 1'b1, 7, 4'b0000, 1'b1, 8'h3C};
    tbl[3]  = '{8'h96, 1'b1, 7, 4'b0000, 1'b1, 8'h96};
    tbl[4]  = '{8'h5A, 1'b1, 7, 4'b0100, 1'b1, 8'h5A};
    tbl[5]  = '{8'hD5, 1'b1, 7, 4'b1000, 1'b0, 8'h5A};
    tbl[6]  = '{8'hA5, 1'b0, 7, 4'b0000, 1'b1, 8'hA5};
    tbl[7]  = '{8'h3C, 1'b0, 7, 4'b0001, 1'b1, 8'hA5};
    tbl[8]  = '{8'h96, 1'b0, 7, 4'b0001, 1'b1, 8'hA5};
    tbl[9]  = '{8'h5A, 1'b0, 7, 4'b0101, 1'b1, 8'hA5};
    tbl[10] = '{8'hD5, 1'b1, 7, 4'b1000, 1'b0, 8'hA5};
    tbl[11] = '{8'h80, 1'b1, 5, 4'b0010, 1'b0, 8'hA5};
    tbl[12] = '{8'hD5, 1'b1, 7, 4'b1000, 1'b0, 8'hA5};
    exp_xfer = '{8'hA5, 8'h3C, 8'h96, 8'h5A, 8'hA5};

    rst_n = 1'b0; bit_en = 1'b0; line_in = 1'b0; out_ready = 1'b0; enc_line = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pulses", 32'(pulses()), 32'd0);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle pulses", 32'(pulses()), 32'd0);

    apply(0, 9);

    // Drain the word held through the overflowed frame
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain valid", 32'(out_valid), 32'd0);
    check("drain data hold", 32'(out_data), 32'hA5);

    apply(10, 12);

    // Long strobe gap mid-word while the line wiggles
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_bit(tbl[1].byte_v[b]);
    for (int c = 0; c < 20; c++) begin
      line_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("stall pulses", 32'(pulses()), 32'd0);
    check("stall valid", 32'(out_valid), 32'd0);
    for (int b = 4; b < 8; b++) send_bit(tbl[1].byte_v[b]);
    check("resume valid", 32'(out_valid), 32'd1);
    check("resume data", 32'(out_data), 32'hA5);

    // Asynchronous reset mid-word with a pending output word
    for (int b = 0; b < 3; b++) send_bit(tbl[2].byte_v[b]);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst data", 32'(out_data), 32'd0);
    line_in = 1'b0;
    enc_line = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      send_bit(tbl[4].byte_v[b]);
      check($sformatf("post rst 5A b%0d pulses", b), 32'(pulses()), 32'd0);
    end
    check("post rst hunt valid", 32'(out_valid), 32'd0);
    for (int b = 0; b < 8; b++) begin
      send_bit(tbl[0].byte_v[b]);
      check($sformatf("post rst D5 b%0d pulses", b), 32'(pulses()),
            (b == 7) ? 32'h8 : 32'd0);
    end

    check("xfer count", 32'(xfer_q.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      check($sformatf("xfer %0d", k),
            (k < xfer_q.size()) ? 32'(xfer_q[k]) : 32'hDEAD, 32'(exp_xfer[k]));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/nrzi_frame_receiver.md
Name: nrzi_frame_receiver

Overview:
- Receive end of the toggle-encoded (T flip-flop / NRZI) serial link.
- The transmitter toggles the line for a 1 and holds it for a 0. This block recovers each bit as line XOR previous line, hunts for a sync byte, and deserializes a fixed-length frame into words.
- Words are delivered over a valid/ready handshake. The block also detects line stall (long runs of no toggles) and output overflow.

Parameters:
- WIDTH, 8, bits per data word, 2..16.
- SYNC, 8'hD5, 8-bit sync pattern, compared against the last 8 decoded bits.
- FRAME_WORDS, 4, data words per frame after sync, 1..255.
- RUN_MAX, 6, consecutive decoded 0s in RECV that abort the frame, 2..WIDTH+7.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_en  in  1  bit strobe; line_in is sampled only on cycles where bit_en=1.
- line_in  in  1  toggle-encoded serial line.
- out_data  out  WIDTH  received word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid&out_ready.
- sync_found  out  1  one-cycle pulse: sync matched, frame starts.
- frame_done  out  1  one-cycle pulse: last word of the frame completed.
- err  out  1  one-cycle pulse: run-length abort.
- ovf  out  1  one-cycle pulse: a word completed while the output register was full and not being read; that word is dropped.

Behaviour:
- Reset (async, rst_n=0):
  - prev_line=0, sync shift register=0, state=HUNT, all counters=0.
  - out_data=0, out_valid=0, all pulse outputs=0.
  - Reset mid-frame discards everything, including a pending output word.
- Bit decode:
  - On a bit_en cycle, d = line_in ^ prev_line and prev_line <= line_in.
  - On cycles with bit_en=0, no state changes, except the output handshake.
  - All effects of a bit are registered and visible in the cycle after its bit_en.
- State HUNT:
  - sync_sr <= {d, sync_sr[7:1]}; the first-received bit ends in bit 0.
  - If the new sync_sr value equals SYNC: pulse sync_found, go to RECV, clear bit_cnt, word_cnt and run_cnt.
  - No data is captured in HUNT.
  - On leaving RECV, sync_sr is cleared to 0, so a new sync needs 8 fresh bits.
- State RECV:
  - Shift register is filled LSB first: shreg <= {d, shreg[WIDTH-1:1]}; bit_cnt increments.
  - run_cnt increments on d=0 and clears on d=1.
  - Abort: if run_cnt reaches RUN_MAX, pulse err, discard the partial word, go to HUNT. Abort has priority over word completion on the same bit.
  - Word completion: when bit_cnt reaches WIDTH, the completed word is presented to the output register.
    - If out_valid=0, or out_valid&out_ready in the same cycle: load out_data and set out_valid=1.
    - Otherwise: drop the word, pulse ovf, keep out_data unchanged.
    - In both cases bit_cnt clears and word_cnt increments.
  - When word_cnt reaches FRAME_WORDS: pulse frame_done in the same cycle as the completion, then go to HUNT. run_cnt is not reset between words.
- Output handshake:
  - out_valid&out_ready with no new load clears out_valid; out_data holds its value.
  - out_valid never drops without a transfer, and out_data never changes while out_valid=1 and not accepted.
- Counter widths:
  - bit_cnt: clog2(WIDTH+1) bits.
  - word_cnt: 8 bits.
  - run_cnt: saturates at RUN_MAX.

Test Plan:
- Reset with line idle at 0, then send bits D5 (LSB first) as toggles -> sync_found pulses one cycle after the 8th bit_en; all outputs were 0 before that.
- After sync, send words A5, 3C, 96, 5A with out_ready=1 -> four out_valid transfers with exactly those values, frame_done coincident with the 5A load, then state returns to HUNT.
- Same frame with out_ready=0 -> out_data=A5 stays valid; ovf pulses for 3C, 96 and 5A; frame_done still pulses.
- Then raise out_ready -> A5 is transferred and out_valid drops.
- After sync, send word 0x80 -> bits 0–6 are decoded 0s; err pulses on the 6th zero; no out_valid; the next D5 re-syncs.
- Hold bit_en=0 for 20 cycles mid-word while line_in toggles -> no change; decoding resumes correctly on the next strobe.
- Assert rst_n=0 asynchronously mid-word with out_valid=1 -> out_valid=0 and out_data=0 immediately. After release, the block stays in HUNT until a full D5.
